// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS sequencing controller.
//   state_t      : FSM state codes (also visible on the debug state port)
//   NPC_*        : npc_op codes driven to the NPC
//   A3_SEL_*     : GRF write-address select codes
//   WD_SEL_*     : GRF write-data select codes
//   OP_* / FN_*  : opcode and funct field constants
//   mc_class_t   : one-hot instruction class produced by mc_class_dec
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_B   = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] A3_SEL_RD = 2'd0;
  localparam logic [1:0] A3_SEL_RT = 2'd1;
  localparam logic [1:0] A3_SEL_RA = 2'd2;

  localparam logic [1:0] WD_SEL_ALU = 2'd0;
  localparam logic [1:0] WD_SEL_DM  = 2'd1;
  localparam logic [1:0] WD_SEL_PC4 = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef struct packed {
    logic ralu;
    logic jr;
    logic ialu;
    logic lw;
    logic sw;
    logic br;
    logic j;
    logic jal;
    logic ill;
  } mc_class_t;

  function automatic logic is_ralu_funct(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_SLL);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: request/acknowledge handshake between the controller and the
// instruction and data memories.
//   im_req / im_ack : instruction fetch request / instruction data valid
//   dm_req / dm_ack : data access request / data access complete
//   dm_we           : store qualifier, meaningful only while dm_req is high
// master = controller side, slave = memory side.
interface mc_ctrl_if;
  logic im_req;
  logic im_ack;
  logic dm_req;
  logic dm_we;
  logic dm_ack;

  modport master (output im_req, output dm_req, output dm_we,
                  input  im_ack, input  dm_ack);
  modport slave  (input  im_req, input  dm_req, input  dm_we,
                  output im_ack, output dm_ack);
endinterface

// File: rtl/mc_ctrl_class_dec.sv
// mc_class_dec: combinational instruction classifier.
//   opcode : Instr[31:26]
//   funct  : Instr[5:0]
//   cls    : one-hot class; exactly one member is set for any input
module mc_class_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output mc_class_t  cls
);

  always_comb begin
    cls = '0;
    if (opcode == OP_RTYPE) begin
      if (is_ralu_funct(funct))   cls.ralu = 1'b1;
      else if (funct == FN_JR)    cls.jr   = 1'b1;
      else                        cls.ill  = 1'b1;
    end else begin
      case (opcode)
        OP_ORI, OP_LUI, OP_ADDI: cls.ialu = 1'b1;
        OP_LW:                   cls.lw   = 1'b1;
        OP_SW:                   cls.sw   = 1'b1;
        OP_BEQ, OP_BNE:          cls.br   = 1'b1;
        OP_J:                    cls.j    = 1'b1;
        OP_JAL:                  cls.jal  = 1'b1;
        default:                 cls.ill  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencing controller for the MIPS datapath.
// Decides when GRF/PC/IR/DM are written; the datapath decoder supplies the
// operation codes themselves.
//   clk, reset      : clock, synchronous active-low reset
//   opcode, funct   : instruction register fields
//   jump            : CMP branch-condition result
//   mem             : memory handshake (im_req/im_ack, dm_req/dm_we/dm_ack)
//   ir_we, grf_we, pc_we : one-cycle write strobes
//   npc_op, a3_sel, wd_sel : datapath selects
//   state           : current FSM state (debug)
//   illegal         : pulse on an unrecognised instruction
//   halted          : sticky memory-ack timeout
//   retired         : count of pc_we pulses
//
// state  | meaning
// FETCH  | request instruction, latch IR on im_ack
// DECODE | jumps and illegal instructions retire here
// EXEC   | branches retire here, others pick MEM or WB
// MEM    | data access, stores retire on dm_ack
// WB     | register write-back and PC+4
// HALT   | memory ack timeout, left only by reset
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             jump,
  mc_ctrl_if.master        mem,
  output logic             ir_we,
  output logic             grf_we,
  output logic             pc_we,
  output logic [1:0]       npc_op,
  output logic [1:0]       a3_sel,
  output logic [1:0]       wd_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT);

  state_t           st_q, st_d;
  mc_class_t        cls;
  logic             halted_q;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] retired_q;
  logic             tmo_hit;
  logic             waiting;

  logic im_req_c, dm_req_c, dm_we_c, ir_we_c, grf_we_c, pc_we_c, illegal_c;
  logic [1:0] npc_op_c, a3_sel_c, wd_sel_c;

  mc_class_dec u_class_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  // Down-counter holds the remaining wait budget; a value of 1 means this is
  // the last cycle a request may go unacknowledged.
  assign tmo_hit = (ACK_TIMEOUT != 0) && (tmo_q == TMO_W'(1));
  assign waiting = (im_req_c && !mem.im_ack) || (dm_req_c && !mem.dm_ack);

  always_comb begin
    st_d      = st_q;
    im_req_c  = 1'b0;
    dm_req_c  = 1'b0;
    dm_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    grf_we_c  = 1'b0;
    pc_we_c   = 1'b0;
    illegal_c = 1'b0;
    npc_op_c  = NPC_PC4;
    a3_sel_c  = A3_SEL_RD;
    wd_sel_c  = WD_SEL_ALU;
    case (st_q)
      ST_FETCH: begin
        im_req_c = 1'b1;
        if (mem.im_ack) begin
          ir_we_c = 1'b1;
          st_d    = ST_DECODE;
        end else if (tmo_hit) begin
          st_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (cls.j || cls.jal) begin
          pc_we_c  = 1'b1;
          npc_op_c = NPC_J;
          if (cls.jal) begin
            grf_we_c = 1'b1;
            a3_sel_c = A3_SEL_RA;
            wd_sel_c = WD_SEL_PC4;
          end
          st_d = ST_FETCH;
        end else if (cls.jr) begin
          pc_we_c  = 1'b1;
          npc_op_c = NPC_JR;
          st_d     = ST_FETCH;
        end else if (cls.ill) begin
          pc_we_c   = 1'b1;
          illegal_c = 1'b1;
          st_d      = ST_FETCH;
        end else begin
          st_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls.br) begin
          pc_we_c  = 1'b1;
          npc_op_c = jump ? NPC_B : NPC_PC4;
          st_d     = ST_FETCH;
        end else if (cls.lw || cls.sw) begin
          st_d = ST_MEM;
        end else if (cls.ralu || cls.ialu) begin
          st_d = ST_WB;
        end else begin
          st_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        dm_req_c = 1'b1;
        dm_we_c  = cls.sw;
        if (mem.dm_ack) begin
          if (cls.sw) begin
            pc_we_c = 1'b1;
            st_d    = ST_FETCH;
          end else begin
            st_d = ST_WB;
          end
        end else if (tmo_hit) begin
          st_d = ST_HALT;
        end
      end
      ST_WB: begin
        grf_we_c = 1'b1;
        pc_we_c  = 1'b1;
        a3_sel_c = cls.ralu ? A3_SEL_RD : A3_SEL_RT;
        wd_sel_c = cls.lw ? WD_SEL_DM : WD_SEL_ALU;
        st_d     = ST_FETCH;
      end
      ST_HALT: st_d = ST_HALT;
      default: st_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q      <= ST_FETCH;
      halted_q  <= 1'b0;
      tmo_q     <= TMO_LOAD;
      retired_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_d == ST_HALT) halted_q <= 1'b1;
      // Any cycle without an outstanding unacknowledged request reloads the
      // budget, which covers entry to FETCH/MEM and every ack.
      if (waiting) tmo_q <= tmo_q - TMO_W'(1);
      else         tmo_q <= TMO_LOAD;
      retired_q <= retired_q + CNT_W'(pc_we_c);
    end
  end

  // While reset is held every output is forced low, withdrawing any request.
  assign mem.im_req = reset & im_req_c;
  assign mem.dm_req = reset & dm_req_c;
  assign mem.dm_we  = reset & dm_we_c;
  assign ir_we      = reset & ir_we_c;
  assign grf_we     = reset & grf_we_c;
  assign pc_we      = reset & pc_we_c;
  assign illegal    = reset & illegal_c;
  assign npc_op     = reset ? npc_op_c : NPC_PC4;
  assign a3_sel     = reset ? a3_sel_c : A3_SEL_RD;
  assign wd_sel     = reset ? wd_sel_c : WD_SEL_ALU;
  assign state      = reset ? st_q : ST_FETCH;
  assign halted     = reset & halted_q;
  assign retired    = reset ? retired_q : '0;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0]  st;
    logic        im_req;
    logic        ir_we;
    logic        dm_req;
    logic        dm_we;
    logic        grf_we;
    logic        pc_we;
    logic [1:0]  npc;
    logic [1:0]  a3;
    logic [1:0]  wd;
    logic        ill;
    logic        halt;
    logic [31:0] ret;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  e;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        jump = 1'b0;
  logic        ir_we, grf_we, pc_we, illegal, halted;
  logic [1:0]  npc_op, a3_sel, wd_sel;
  logic [2:0]  state;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  sb_t         sbq[$];
  logic [31:0] exp_ret = '0;
  logic        exp_halt = 1'b0;

  mc_ctrl_if mem_if ();

  mc_ctrl #(.ACK_TIMEOUT(16), .CNT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .funct   (funct),
    .jump    (jump),
    .mem     (mem_if),
    .ir_we   (ir_we),
    .grf_we  (grf_we),
    .pc_we   (pc_we),
    .npc_op  (npc_op),
    .a3_sel  (a3_sel),
    .wd_sel  (wd_sel),
    .state   (state),
    .illegal (illegal),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d im_req=%0b ir_we=%0b dm_req=%0b dm_we=%0b grf_we=%0b pc_we=%0b npc=%0d a3=%0d wd=%0d ill=%0b halt=%0b ret=%0d",
                     o.st, o.im_req, o.ir_we, o.dm_req, o.dm_we, o.grf_we, o.pc_we,
                     o.npc, o.a3, o.wd, o.ill, o.halt, o.ret);
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin : monitor
    sb_t  s;
    obs_t a;
    if (sbq.size() > 0) begin
      s = sbq.pop_front();
      a = {state, mem_if.im_req, ir_we, mem_if.dm_req, mem_if.dm_we, grf_we, pc_we,
           npc_op, a3_sel, wd_sel, illegal, halted, retired};
      checks++;
      if (a !== s.e) begin
        errors++;
        $display("FAIL %s: got %s | expected %s", s.nm, fmt(a), fmt(s.e));
      end
    end
  end

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  // strb = {im_req, ir_we, dm_req, dm_we, grf_we, pc_we}
  task automatic cyc(input string nm, input logic iack, input logic dack, input logic jmp,
                     input logic [2:0] st, input logic [5:0] strb,
                     input logic [1:0] npc, input logic [1:0] a3, input logic [1:0] wd,
                     input logic ill);
    sb_t s;
    reset = 1'b1;
    mem_if.im_ack = iack;
    mem_if.dm_ack = dack;
    jump = jmp;
    s.nm = nm;
    s.e.st = st;
    {s.e.im_req, s.e.ir_we, s.e.dm_req, s.e.dm_we, s.e.grf_we, s.e.pc_we} = strb;
    s.e.npc  = npc;
    s.e.a3   = a3;
    s.e.wd   = wd;
    s.e.ill  = ill;
    s.e.halt = exp_halt;
    s.e.ret  = exp_ret;
    sbq.push_back(s);
    if (strb[0]) exp_ret = exp_ret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cyc(input string nm);
    sb_t s;
    reset = 1'b0;
    mem_if.im_ack = 1'b1;
    mem_if.dm_ack = 1'b1;
    s.nm = nm;
    s.e  = '0;
    sbq.push_back(s);
    exp_ret  = '0;
    exp_halt = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_if.im_ack = 1'b0;
    mem_if.dm_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_cyc("reset0");
    rst_cyc("reset1");

    // R-type add, im_ack tied high, stray dm_ack in EXEC
    set_ir(OP_RTYPE, FN_ADD);
    cyc("add.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("add.dec",   1, 0, 0, 3'd1, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("add.exec",  1, 1, 0, 3'd2, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("add.wb",    1, 0, 0, 3'd4, 6'b000011, NPC_PC4, A3_SEL_RD, WD_SEL_ALU, 0);

    // lw with 3 data wait cycles
    set_ir(OP_LW, 6'd0);
    cyc("lw.fetch",  1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("lw.dec",    1, 0, 0, 3'd1, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("lw.exec",   1, 0, 0, 3'd2, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    for (int i = 0; i < 3; i++)
      cyc("lw.mem_wait", 1, 0, 0, 3'd3, 6'b001000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("lw.mem_ack", 1, 1, 0, 3'd3, 6'b001000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("lw.wb",      1, 0, 0, 3'd4, 6'b000011, NPC_PC4, A3_SEL_RT, WD_SEL_DM, 0);

    // beq taken, bne not taken
    set_ir(OP_BEQ, 6'd0);
    cyc("beq.fetch", 1, 0, 1, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("beq.dec",   1, 0, 1, 3'd1, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("beq.exec",  1, 0, 1, 3'd2, 6'b000001, NPC_B,   2'd0, 2'd0, 0);
    set_ir(OP_BNE, 6'd0);
    cyc("bne.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("bne.dec",   1, 0, 0, 3'd1, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("bne.exec",  1, 0, 0, 3'd2, 6'b000001, NPC_PC4, 2'd0, 2'd0, 0);

    // jal, j, jr
    set_ir(OP_JAL, 6'd0);
    cyc("jal.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("jal.dec",   1, 0, 0, 3'd1, 6'b000011, NPC_J, A3_SEL_RA, WD_SEL_PC4, 0);
    set_ir(OP_J, 6'd0);
    cyc("j.fetch",   1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("j.dec",     1, 0, 0, 3'd1, 6'b000001, NPC_J, 2'd0, 2'd0, 0);
    set_ir(OP_RTYPE, FN_JR);
    cyc("jr.fetch",  1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("jr.dec",    1, 0, 0, 3'd1, 6'b000001, NPC_JR, 2'd0, 2'd0, 0);

    // illegal opcode and illegal R-type funct
    set_ir(6'b111111, 6'd0);
    cyc("ill_op.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("ill_op.dec",   1, 0, 0, 3'd1, 6'b000001, NPC_PC4, 2'd0, 2'd0, 1);
    set_ir(OP_RTYPE, 6'b111111);
    cyc("ill_fn.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("ill_fn.dec",   1, 0, 0, 3'd1, 6'b000001, NPC_PC4, 2'd0, 2'd0, 1);

    // sw with zero-wait dm_ack
    set_ir(OP_SW, 6'd0);
    cyc("sw.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("sw.dec",   1, 0, 0, 3'd1, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("sw.exec",  1, 0, 0, 3'd2, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("sw.mem",   1, 1, 0, 3'd3, 6'b001101, NPC_PC4, 2'd0, 2'd0, 0);

    // ori with two fetch wait cycles
    set_ir(OP_ORI, 6'd0);
    cyc("ori.fetch_wait", 0, 0, 0, 3'd0, 6'b100000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("ori.fetch_wait", 0, 0, 0, 3'd0, 6'b100000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("ori.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("ori.dec",   1, 0, 0, 3'd1, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("ori.exec",  1, 0, 0, 3'd2, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("ori.wb",    1, 0, 0, 3'd4, 6'b000011, NPC_PC4, A3_SEL_RT, WD_SEL_ALU, 0);

    // ack in the last allowed cycle wins over the timeout
    set_ir(OP_J, 6'd0);
    for (int i = 0; i < 15; i++)
      cyc("edge.fetch_wait", 0, 0, 0, 3'd0, 6'b100000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("edge.fetch_ack", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("edge.dec",       1, 0, 0, 3'd1, 6'b000001, NPC_J, 2'd0, 2'd0, 0);

    // 16 unacknowledged cycles -> HALT
    for (int i = 0; i < 16; i++)
      cyc("tmo.fetch_wait", 0, 0, 0, 3'd0, 6'b100000, NPC_PC4, 2'd0, 2'd0, 0);
    exp_halt = 1'b1;
    cyc("tmo.halt0", 1, 1, 1, 3'd7, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("tmo.halt1", 1, 1, 0, 3'd7, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    rst_cyc("tmo.reset");
    cyc("post_rst.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("post_rst.dec",   1, 0, 0, 3'd1, 6'b000001, NPC_J, 2'd0, 2'd0, 0);

    // reset in mid-MEM withdraws the store request
    set_ir(OP_SW, 6'd0);
    cyc("swr.fetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("swr.dec",   1, 0, 0, 3'd1, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("swr.exec",  1, 0, 0, 3'd2, 6'b000000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("swr.mem_wait", 1, 0, 0, 3'd3, 6'b001100, NPC_PC4, 2'd0, 2'd0, 0);
    rst_cyc("swr.reset");
    set_ir(OP_J, 6'd0);
    cyc("swr.refetch", 1, 0, 0, 3'd0, 6'b110000, NPC_PC4, 2'd0, 2'd0, 0);
    cyc("swr.dec",     1, 0, 0, 3'd1, 6'b000001, NPC_J, 2'd0, 2'd0, 0);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencing controller for the MIPS datapath: GRF, ALU, DM, NPC, CMP and EXT. It walks each instruction through the FETCH/DECODE/EXEC/MEM/WB states and issues one-cycle write strobes, mux selects and NPC opcodes. It handshakes with variable-latency instruction and data memories. The existing combinational decoder keeps producing ALUOp/EXTOp/ALUBSel/DMOp; this block only decides when state is written.

Parameters:
ACK_TIMEOUT, 16, max cycles a memory request may wait for ack; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled 0 at posedge => reset)
opcode  in  6  Instr[31:26] of the instruction register
funct  in  6  Instr[5:0] of the instruction register
jump  in  1  CMP branch-condition result
im_ack  in  1  instruction memory data valid
dm_ack  in  1  data memory access complete
im_req  out  1  instruction fetch request
ir_we  out  1  latch instruction register
dm_req  out  1  data memory request
dm_we  out  1  store qualifier, valid only with dm_req
grf_we  out  1  GRF write strobe
pc_we  out  1  PC update strobe, exactly one pulse per instruction
npc_op  out  2  0=PC4, 1=branch, 2=J/JAL, 3=JR
a3_sel  out  2  0=rd, 1=rt, 2=ra(31)
wd_sel  out  2  0=ALU, 1=DM read, 2=PC4
state  out  3  current state, for debug
illegal  out  1  one-cycle pulse on an unrecognised instruction
halted  out  1  sticky timeout error
retired  out  CNT_W  count of pc_we pulses, wraps modulo 2^CNT_W

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. All outputs are combinational from state plus inputs; the strobes default to 0.
- Classes:
  - RALU: opcode 0, funct add/sub/and/or/slt/sll.
  - JR: opcode 0, funct 001000.
  - IALU: ori 001101, lui 001111, addi 001000.
  - LW: 100011. SW: 101011. BR: beq 000100, bne 000101.
  - J: 000010. JAL: 000011.
  - Anything else is ILL.
- FETCH: im_req=1. When im_ack=1 in the same cycle, ir_we=1 and the next state is DECODE. A zero-wait ack is legal.
- DECODE:
  - J: pc_we=1, npc_op=2 -> FETCH.
  - JAL: additionally grf_we=1, a3_sel=2, wd_sel=2 -> FETCH.
  - JR: pc_we=1, npc_op=3 -> FETCH.
  - ILL: pc_we=1, npc_op=0, illegal=1 -> FETCH.
  - Everything else -> EXEC.
- EXEC:
  - BR: pc_we=1, npc_op = jump ? 1 : 0 -> FETCH.
  - LW/SW -> MEM.
  - RALU/IALU -> WB.
- MEM: dm_req=1; dm_we=1 for SW. On dm_ack:
  - SW: pc_we=1, npc_op=0 -> FETCH.
  - LW -> WB.
- WB: grf_we=1, pc_we=1, npc_op=0 -> FETCH.
  - RALU: a3_sel=0, wd_sel=0.
  - IALU: a3_sel=1, wd_sel=0.
  - LW: a3_sel=1, wd_sel=1.
- Minimum latency per class (cycles): RALU/IALU 4, LW 5, SW 4, BR 3, J/JAL/JR/ILL 2. Each memory wait cycle adds 1.
- Class is decoded from opcode/funct in every state. The IR is stable after DECODE because ir_we is asserted only in FETCH.
- Timeout counter:
  - Clears on entry to FETCH and MEM, and on every ack.
  - Increments each cycle a request is held without ack.
  - When ACK_TIMEOUT != 0 and the count reaches ACK_TIMEOUT with no ack, the next state is HALT and halted goes to 1.
  - An ack arriving in the same cycle the count reaches the limit wins; no halt.
- HALT: all strobes 0, im_req=dm_req=0. Only reset leaves HALT.
- Acks arriving while no request is asserted are ignored.
- retired increments on every pc_we=1 cycle, wrapping to 0 after 2^CNT_W-1.
- Reset (reset=0 at posedge):
  - state=FETCH, timeout=0, halted=0, retired=0.
  - While reset=0, all outputs are forced to 0, including im_req.
  - A reset in mid-MEM or mid-FETCH drops the request immediately and no strobe is issued. The memory must tolerate a withdrawn request.

Decomposition:
- Shared header def.v gains: state codes, npc_op codes (NPC_PC4/B/J/JR), opcode/funct constants, A3Sel/WDSel codes. Reuse the existing A3Sel_*/WDSel_* macros and keep their values.
- One natural sub-module: mc_class_dec. It is combinational (opcode, funct -> one-hot class) and shareable with a future pipelined decoder.

Test Plan:
1. Reset low 2 cycles, then addu-type R (op 0, funct 100000), im_ack tied 1 -> states 0,1,2,4. pc_we and grf_we only in cycle 4; a3_sel=0, wd_sel=0; retired=1.
2. lw (100011), im_ack immediate, dm_ack after 3 wait cycles -> dm_req held 4 cycles, dm_we=0. Then WB with a3_sel=1, wd_sel=1. 8 cycles total.
3. beq with jump=1, then bne with jump=0 -> EXEC pc_we=1 with npc_op=1, then npc_op=0; no grf_we; 3 cycles each.
4. jal (000011) -> DECODE asserts pc_we, grf_we, npc_op=2, a3_sel=2, wd_sel=2; back in FETCH the next cycle.
5. Opcode 111111 -> illegal pulses once in DECODE, pc_we with npc_op=0, retired increments.
6. im_ack held 0 with ACK_TIMEOUT=16 -> halted=1 and state=7 after the 16th wait cycle, all strobes 0. Then reset=0 for one cycle -> state=0, halted=0, retired=0.
